// File: rtl/jtgng_sdram_arb.sv
// -----------------------------------------------------------------------------
// jtgng_sdram_arb
// Round-robin arbiter sharing one SDRAM read controller among four ROM slots.
// Each slot keeps a one-word cache (valid, tag, data) so repeated reads of the
// same address are served without touching the SDRAM.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   downloading         ROM download in progress: arbiter idles, caches flushed
//   loop_rst            controller initialising: same effect as downloading
//   slotN_cs/addr       slot N request and word address (before OFFSETN)
//   slotN_dout/ok       slot N cached word and "dout valid for current addr"
//   read_req/sdram_addr request and address towards the SDRAM controller
//   sdram_ack           controller accepted the request (1-cycle pulse)
//   data_rdy/data_read  controller read complete and its data
//   refresh_en          controller may run autorefresh
// -----------------------------------------------------------------------------
module jtgng_sdram_arb #(
    parameter logic [21:0] OFFSET0  = 22'h0,
    parameter logic [21:0] OFFSET1  = 22'h0,
    parameter logic [21:0] OFFSET2  = 22'h0,
    parameter logic [21:0] OFFSET3  = 22'h0,
    parameter int          DATA_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic        loop_rst,
    input  logic        slot0_cs,
    input  logic [21:0] slot0_addr,
    output logic [31:0] slot0_dout,
    output logic        slot0_ok,
    input  logic        slot1_cs,
    input  logic [21:0] slot1_addr,
    output logic [31:0] slot1_dout,
    output logic        slot1_ok,
    input  logic        slot2_cs,
    input  logic [21:0] slot2_addr,
    output logic [31:0] slot2_dout,
    output logic        slot2_ok,
    input  logic        slot3_cs,
    input  logic [21:0] slot3_addr,
    output logic [31:0] slot3_dout,
    output logic        slot3_ok,
    output logic        read_req,
    output logic [21:0] sdram_addr,
    input  logic        sdram_ack,
    input  logic        data_rdy,
    input  logic [31:0] data_read,
    output logic        refresh_en
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_LAT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        w_halt;
    logic [3:0]  w_cs;
    logic [3:0]  w_hit;
    logic [3:0]  w_pend;
    logic [21:0] w_addr [4];

    logic [3:0]  r_valid;
    logic [21:0] r_tag  [4];
    logic [31:0] r_data [4];

    logic [1:0]  r_rr;
    logic [1:0]  r_gnt;
    logic [1:0]  r_cnt;
    logic        r_read_req;
    logic [21:0] r_sdram_addr;
    logic        r_refresh_en;

    logic        w_found;
    logic [1:0]  w_grant;
    logic [1:0]  w_idx;
    logic        w_do_grant;
    logic        w_capture;
    logic        w_load_lat;

    assign w_halt = downloading | loop_rst;
    assign w_cs   = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};

    // Offsets wrap naturally in 22 bits
    assign w_addr[0] = slot0_addr + OFFSET0;
    assign w_addr[1] = slot1_addr + OFFSET1;
    assign w_addr[2] = slot2_addr + OFFSET2;
    assign w_addr[3] = slot3_addr + OFFSET3;

    assign slot0_dout = r_data[0];
    assign slot1_dout = r_data[1];
    assign slot2_dout = r_data[2];
    assign slot3_dout = r_data[3];
    assign slot0_ok   = w_cs[0] & w_hit[0];
    assign slot1_ok   = w_cs[1] & w_hit[1];
    assign slot2_ok   = w_cs[2] & w_hit[2];
    assign slot3_ok   = w_cs[3] & w_hit[3];

    assign read_req   = r_read_req;
    assign sdram_addr = r_sdram_addr;
    assign refresh_en = r_refresh_en;

    // Cache hit and pending-miss flags per slot
    always_comb begin
        w_hit  = 4'd0;
        w_pend = 4'd0;
        for (int i = 0; i < 4; i++) begin
            w_hit[i]  = r_valid[i] & (r_tag[i] == w_addr[i]);
            w_pend[i] = w_cs[i] & ~w_hit[i];
        end
    end

    // Round-robin search starting at the slot after the last grant
    always_comb begin
        w_found = 1'b0;
        w_grant = r_rr;
        w_idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_rr + 2'(k);
            if (!w_found && w_pend[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end else begin
                w_grant = w_grant;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state and transaction strobes
    always_comb begin
        w_next     = r_state;
        w_do_grant = 1'b0;
        w_capture  = 1'b0;
        w_load_lat = 1'b0;
        if (w_halt) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        w_do_grant = 1'b1;
                        w_next     = ST_REQ;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (sdram_ack) begin
                        w_next = ST_WAIT;
                    end else begin
                        w_next = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (data_rdy) begin
                        if (DATA_LAT == 0) begin
                            w_capture = 1'b1;
                            w_next    = ST_IDLE;
                        end else begin
                            w_load_lat = 1'b1;
                            w_next     = ST_LAT;
                        end
                    end else begin
                        w_next = ST_WAIT;
                    end
                end
                ST_LAT: begin
                    if (r_cnt == 2'd1) begin
                        w_capture = 1'b1;
                        w_next    = ST_IDLE;
                    end else begin
                        w_next = ST_LAT;
                    end
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    // Request path, round-robin pointer, latency counter and refresh permit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read_req   <= 1'b0;
            r_sdram_addr <= 22'd0;
            r_rr         <= 2'd3;
            r_gnt        <= 2'd0;
            r_cnt        <= 2'd0;
            r_refresh_en <= 1'b0;
        end else begin
            // read_req is high exactly while the FSM sits in REQ
            r_read_req   <= (w_next == ST_REQ);
            r_refresh_en <= (r_state == ST_IDLE) && (w_pend == 4'd0) && !w_halt;
            if (w_do_grant) begin
                r_sdram_addr <= w_addr[w_grant];
                r_rr         <= w_grant;
                r_gnt        <= w_grant;
            end
            if (w_load_lat) begin
                r_cnt <= 2'(DATA_LAT);
            end else if (r_state == ST_LAT) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end
    end

    // Per-slot cache; tag is the address actually issued, not the current one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                r_tag[i]  <= 22'd0;
                r_data[i] <= 32'd0;
            end
        end else if (w_halt) begin
            r_valid <= 4'd0;
        end else if (w_capture) begin
            r_valid[r_gnt] <= 1'b1;
            r_tag[r_gnt]   <= r_sdram_addr;
            r_data[r_gnt]  <= data_read;
        end
    end

endmodule

// File: tb/tb_jtgng_sdram_arb.sv
// -----------------------------------------------------------------------------
// tb_jtgng_sdram_arb
// Self-checking bench: a behavioural SDRAM controller stub answers read_req;
// expected request addresses are queued when slots are driven and compared
// when the stub sees each request. Slot data is checked against the stub's
// memory function.
// -----------------------------------------------------------------------------
module tb_jtgng_sdram_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        downloading;
    logic        loop_rst;
    logic [3:0]  cs_v;
    logic [21:0] addr_v [4];
    logic [31:0] dout_v [4];
    logic [3:0]  ok_v;
    logic        read_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        data_rdy;
    logic [31:0] data_read;
    logic        refresh_en;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_req    = 0;
    int          n_ack    = 0;
    logic        stub_hold = 1'b0;
    logic [21:0] q_addr [$];
    logic [21:0] stub_a;
    int          stub_guard;

    jtgng_sdram_arb #(
        .OFFSET0  (22'h0),
        .OFFSET1  (22'h0),
        .OFFSET2  (22'h3F_FFF0),
        .OFFSET3  (22'h0),
        .DATA_LAT (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .loop_rst    (loop_rst),
        .slot0_cs    (cs_v[0]),
        .slot0_addr  (addr_v[0]),
        .slot0_dout  (dout_v[0]),
        .slot0_ok    (ok_v[0]),
        .slot1_cs    (cs_v[1]),
        .slot1_addr  (addr_v[1]),
        .slot1_dout  (dout_v[1]),
        .slot1_ok    (ok_v[1]),
        .slot2_cs    (cs_v[2]),
        .slot2_addr  (addr_v[2]),
        .slot2_dout  (dout_v[2]),
        .slot2_ok    (ok_v[2]),
        .slot3_cs    (cs_v[3]),
        .slot3_addr  (addr_v[3]),
        .slot3_dout  (dout_v[3]),
        .slot3_ok    (ok_v[3]),
        .read_req    (read_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read),
        .refresh_en  (refresh_en)
    );

    always #5 clk = ~clk;

    // Stub memory contents
    function automatic logic [31:0] mem(input logic [21:0] a);
        if (a == 22'h100) begin
            mem = 32'hDEAD_BEEF;
        end else begin
            mem = {a, 10'h155} ^ 32'h1234_5678;
        end
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ok(input int s, input int budget);
        int n;
        n = 0;
        while (ok_v[s] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val($sformatf("ok_slot%0d", s), 64'(ok_v[s]), 64'd1);
    endtask

    // Controller stub: ack one cycle after request, data_rdy two cycles later,
    // data_read valid only in the single cycle after data_rdy (DATA_LAT=1)
    initial begin
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        data_read = 32'h0BAD_F00D;
        forever begin
            @(negedge clk);
            if (read_req === 1'b1) begin
                stub_a = sdram_addr;
                n_req++;
                if (q_addr.size() > 0) begin
                    check_val("sdram_addr", 64'(stub_a), 64'(q_addr.pop_front()));
                end else begin
                    check_val("req_expected", 64'd0, 64'd1);
                end
                stub_guard = 0;
                while (stub_hold && read_req && stub_guard < 500) begin
                    @(negedge clk);
                    stub_guard++;
                end
                if (read_req) begin
                    @(negedge clk);
                    sdram_ack = 1'b1;
                    @(negedge clk);
                    sdram_ack = 1'b0;
                    n_ack++;
                    @(negedge clk);
                    @(negedge clk);
                    data_rdy = 1'b1;
                    @(negedge clk);
                    data_rdy  = 1'b0;
                    data_read = mem(stub_a);
                    @(negedge clk);
                    data_read = 32'h0BAD_F00D;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog n_checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [21:0] full [4];
        int base;
        int g;
        rst = 1'b1;
        downloading = 1'b0;
        loop_rst = 1'b0;
        cs_v = 4'd0;
        for (int i = 0; i < 4; i++) addr_v[i] = 22'd0;
        repeat (3) @(negedge clk);
        check_val("rst_read_req", 64'(read_req), 64'd0);
        check_val("rst_sdram_addr", 64'(sdram_addr), 64'd0);
        check_val("rst_refresh", 64'(refresh_en), 64'd0);
        check_val("rst_ok", 64'(ok_v), 64'd0);
        check_val("rst_dout0", 64'(dout_v[0]), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Test 1: single miss then repeated hits
        addr_v[0] = 22'h100;
        cs_v[0] = 1'b1;
        q_addr.push_back(22'h100);
        wait_ok(0, 50);
        check_val("t1_dout", 64'(dout_v[0]), 64'hDEAD_BEEF);
        base = n_req;
        check_val("t1_nreq", 64'(base), 64'd1);
        repeat (5) @(negedge clk);
        check_val("t1_ok_hold", 64'(ok_v[0]), 64'd1);
        cs_v[0] = 1'b0;
        @(negedge clk);
        check_val("t1_ok_nocs", 64'(ok_v[0]), 64'd0);
        cs_v[0] = 1'b1;
        @(negedge clk);
        check_val("t1_ok_recs", 64'(ok_v[0]), 64'd1);
        repeat (3) @(negedge clk);
        check_val("t1_no_new_req", 64'(n_req), 64'(base));
        cs_v[0] = 1'b0;

        // Asynchronous reset clears the cache immediately
        cs_v[0] = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check_val("arst_ok0", 64'(ok_v[0]), 64'd0);
        check_val("arst_dout0", 64'(dout_v[0]), 64'd0);
        cs_v[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Test 2: four simultaneous misses granted 0,1,2,3 (slot2 wraps 0x40+0x3FFFF0)
        addr_v[0] = 22'h200;
        addr_v[1] = 22'h300;
        addr_v[2] = 22'h40;
        addr_v[3] = 22'h500;
        full[0] = 22'h200;
        full[1] = 22'h300;
        full[2] = 22'h30;
        full[3] = 22'h500;
        for (int i = 0; i < 4; i++) q_addr.push_back(full[i]);
        cs_v = 4'hF;
        wait_ok(3, 200);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("t2_ok%0d", i), 64'(ok_v[i]), 64'd1);
            check_val($sformatf("t2_dout%0d", i), 64'(dout_v[i]), 64'(mem(full[i])));
        end
        cs_v = 4'd0;
        @(negedge clk);

        // Test 3: offset wrap 0x20 + 0x3FFFF0 -> 0x10
        addr_v[2] = 22'h20;
        cs_v[2] = 1'b1;
        q_addr.push_back(22'h10);
        wait_ok(2, 50);
        check_val("t3_dout", 64'(dout_v[2]), 64'(mem(22'h10)));
        cs_v[2] = 1'b0;
        @(negedge clk);

        // Test 4: address changes while waiting for data
        base = n_req;
        addr_v[1] = 22'h5;
        cs_v[1] = 1'b1;
        q_addr.push_back(22'h5);
        g = n_ack;
        while (n_ack == g && n_ack < g + 1 && g >= 0) begin
            @(negedge clk);
            if (n_req > base + 2) break;
            if ($time > 150000) break;
        end
        @(negedge clk);
        addr_v[1] = 22'h6;
        q_addr.push_back(22'h6);
        wait_ok(1, 100);
        check_val("t4_dout", 64'(dout_v[1]), 64'(mem(22'h6)));
        check_val("t4_nreq", 64'(n_req - base), 64'd2);
        cs_v[1] = 1'b0;
        @(negedge clk);

        // Test 5: download while a request is outstanding
        addr_v[0] = 22'h200;
        addr_v[3] = 22'h700;
        stub_hold = 1'b1;
        q_addr.push_back(22'h700);
        cs_v[0] = 1'b1;
        cs_v[3] = 1'b1;
        g = 0;
        while (read_req !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        check_val("t5_req_seen", 64'(read_req), 64'd1);
        check_val("t5_hit0", 64'(ok_v[0]), 64'd1);
        downloading = 1'b1;
        @(negedge clk);
        check_val("t5_req_drop", 64'(read_req), 64'd0);
        check_val("t5_ok_all", 64'(ok_v), 64'd0);
        check_val("t5_refresh", 64'(refresh_en), 64'd0);
        repeat (3) @(negedge clk);
        check_val("t5_refresh_dl", 64'(refresh_en), 64'd0);
        check_val("t5_req_dl", 64'(read_req), 64'd0);
        q_addr.push_back(22'h200);
        q_addr.push_back(22'h700);
        stub_hold = 1'b0;
        downloading = 1'b0;
        wait_ok(0, 100);
        wait_ok(3, 100);
        check_val("t5_dout0", 64'(dout_v[0]), 64'(mem(22'h200)));
        check_val("t5_dout3", 64'(dout_v[3]), 64'(mem(22'h700)));
        cs_v = 4'd0;

        // Test 6: refresh permitted while idle, withdrawn on a miss
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check_val($sformatf("t6_refresh%0d", i), 64'(refresh_en), 64'd1);
            @(negedge clk);
        end
        addr_v[0] = 22'h900;
        cs_v[0] = 1'b1;
        q_addr.push_back(22'h900);
        @(negedge clk);
        check_val("t6_refresh_off", 64'(refresh_en), 64'd0);
        wait_ok(0, 50);
        check_val("t6_dout", 64'(dout_v[0]), 64'(mem(22'h900)));
        cs_v = 4'd0;

        repeat (3) @(negedge clk);
        check_val("sb_empty", 64'(q_addr.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
